fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 10 +
 rtl/fetch_stage_ifid_reg.sv | 49 ++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, nop and reset vector,
// plus word-aligned PC helpers.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    // Force word alignment; the low two PC bits are never stored as ones.
    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Next sequential PC, modulo 2^32 (0xFFFFFFFC wraps to 0).
    function automatic logic [31:0] pc_inc(input logic [31:0] addr);
        return {addr[31:2] + 30'd1, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register. Flush beats load; a load with nothing delivered
// inserts a bubble (nop, valid=0); otherwise the contents are held.
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic        deliver_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    // Register update: flush, then load (real instruction or bubble), else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            if (deliver_i) begin
                instr_q <= instr_i;
                pc4_q   <= pc4_i;
                valid_q <= 1'b1;
            end else begin
                instr_q <= NOP_INSTR;
                pc4_q   <= 32'h0;
                valid_q <= 1'b0;
            end
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM and one-entry stall buffer, feeding
// the IF/ID register. A redirect arriving mid-access is parked in redir_q
// (DROP) so the address stays stable until the memory completes.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        bus,
    input  logic                 pc_write_i,
    input  logic                 ifid_write_i,
    input  logic                 if_flush_i,
    input  logic                 branch_taken_i,
    input  logic [31:0]          branch_target_i,
    output logic [31:0]          ifid_instr_o,
    output logic [31:0]          ifid_pc4_o,
    output logic                 ifid_valid_o,
    output logic                 fetch_busy_o
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  redir_q;
    logic [31:0]  buf_instr_q;
    logic [31:0]  buf_pc4_q;
    logic         req_q;

    logic         advance;
    logic         fire;
    logic         deliver;
    logic [31:0]  del_instr;
    logic [31:0]  del_pc4;

    assign advance = pc_write_i & ifid_write_i;
    // req_q is low only in HOLD and in the first cycle after reset, so an
    // access completes only while a request is really outstanding.
    assign fire    = bus.imem_ready & req_q;

    // Select what, if anything, enters IF/ID this cycle.
    always_comb begin
        deliver   = 1'b0;
        del_instr = bus.imem_rdata;
        del_pc4   = pc_inc(pc_q);
        case (state_q)
            ST_FETCH: deliver = fire & ~branch_taken_i & advance;
            ST_HOLD: begin
                deliver   = ~branch_taken_i & advance;
                del_instr = buf_instr_q;
                del_pc4   = buf_pc4_q;
            end
            default: deliver = 1'b0;
        endcase
    end

    // Fetch FSM with PC, redirect latch, stall buffer and registered request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_VECTOR;
            redir_q     <= RESET_VECTOR;
            buf_instr_q <= NOP_INSTR;
            buf_pc4_q   <= 32'h0;
            req_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    req_q <= 1'b1;
                    if (fire) begin
                        if (branch_taken_i) begin
                            pc_q <= pc_align(branch_target_i);
                        end else begin
                            pc_q <= pc_inc(pc_q);
                            if (!advance) begin
                                buf_instr_q <= bus.imem_rdata;
                                buf_pc4_q   <= pc_inc(pc_q);
                                state_q     <= ST_HOLD;
                                req_q       <= 1'b0;
                            end
                        end
                    end else if (branch_taken_i) begin
                        redir_q <= pc_align(branch_target_i);
                        state_q <= ST_DROP;
                    end
                end
                ST_HOLD: begin
                    if (branch_taken_i) begin
                        pc_q    <= pc_align(branch_target_i);
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                    end else if (advance) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                ST_DROP: begin
                    req_q <= 1'b1;
                    if (fire) begin
                        pc_q    <= branch_taken_i ? pc_align(branch_target_i) : redir_q;
                        state_q <= ST_FETCH;
                    end else if (branch_taken_i) begin
                        redir_q <= pc_align(branch_target_i);
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = pc_q;
    assign fetch_busy_o  = (state_q != ST_HOLD) & ~fire;

    ifid_reg u_ifid_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (if_flush_i),
        .load_i    (ifid_write_i),
        .deliver_i (deliver),
        .instr_i   (del_instr),
        .pc4_i     (del_pc4),
        .instr_o   (ifid_instr_o),
        .pc4_o     (ifid_pc4_o),
        .valid_o   (ifid_valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an expected-delivery queue: each
// instruction the bench expects in IF/ID is queued when stimulus is driven
// and popped when IF/ID loads a valid entry.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        ifid_write;
    logic        if_flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    fetch_stage_if bus ();

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.imem_rdata = bus.imem_ready ? instr_of(bus.imem_addr) : 32'hDEAD_BEEF;

    fetch_stage u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .pc_write_i      (pc_write),
        .ifid_write_i    (ifid_write),
        .if_flush_i      (if_flush),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .ifid_instr_o    (ifid_instr),
        .ifid_pc4_o      (ifid_pc4),
        .ifid_valid_o    (ifid_valid),
        .fetch_busy_o    (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.instr = instr_of(a);
        e.pc4   = a + 32'd4;
        q.push_back(e);
    endtask

    // One clock; if IF/ID was loaded with a valid entry, compare it to the queue head.
    task automatic step();
        logic loaded;
        exp_t e;
        loaded = ifid_write && !if_flush;
        @(posedge clk);
        #1;
        if (loaded && ifid_valid) begin
            n_cmp++;
            assert (q.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_delivery: observed pc4 %h expected no delivery", ifid_pc4);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_instr", ifid_instr, e.instr);
                chk("sb_pc4", ifid_pc4, e.pc4);
            end
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        rdy;

        rst_n = 1'b0; pc_write = 1'b1; ifid_write = 1'b1; if_flush = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; bus.imem_ready = 1'b0;
        #2;
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_pc4", ifid_pc4, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        bus.imem_ready = 1'b1;

        // first cycle after release: request rises, nothing fetched yet
        step();
        chk("req_rise", {31'h0, bus.imem_req}, 32'h1);
        chk("first_valid", {31'h0, ifid_valid}, 32'h0);

        // straight-line fetch
        for (int i = 0; i < 2; i++) begin
            chk("seq_addr", bus.imem_addr, 32'(4 * i));
            push(32'(4 * i));
            step();
            chk("seq_valid", {31'h0, ifid_valid}, 32'h1);
        end

        // stall: data at pc=8 lands in the buffer, HOLD for three cycles
        pc_write = 1'b0; ifid_write = 1'b0;
        step();
        chk("hold_req", {31'h0, bus.imem_req}, 32'h0);
        chk("hold_addr", bus.imem_addr, 32'd12);
        chk("hold_ifid_pc4", ifid_pc4, 32'd8);
        step(); step();
        chk("hold_req3", {31'h0, bus.imem_req}, 32'h0);
        chk("hold_busy", {31'h0, fetch_busy}, 32'h0);
        pc_write = 1'b1; ifid_write = 1'b1;
        push(32'd8);
        step();
        chk("rel_req", {31'h0, bus.imem_req}, 32'h1);
        chk("rel_addr", bus.imem_addr, 32'd12);
        for (int a = 12; a < 32; a += 4) begin
            chk("resume_addr", bus.imem_addr, 32'(a));
            push(32'(a));
            step();
        end

        // redirect while the access at 0x20 is outstanding; second target wins
        bus.imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h80;
        step();
        chk("drop_addr", bus.imem_addr, 32'h20);
        chk("drop_req", {31'h0, bus.imem_req}, 32'h1);
        chk("drop_busy", {31'h0, fetch_busy}, 32'h1);
        chk("drop_valid", {31'h0, ifid_valid}, 32'h0);
        branch_target = 32'h100;
        step();
        chk("drop_addr2", bus.imem_addr, 32'h20);
        branch_taken = 1'b0; bus.imem_ready = 1'b1;
        step();
        chk("redir_addr", bus.imem_addr, 32'h100);
        chk("redir_valid", {31'h0, ifid_valid}, 32'h0);
        push(32'h100);
        step();

        // branch on a completing access discards the data
        branch_taken = 1'b1; branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        chk("br_fire_addr", bus.imem_addr, 32'h40);
        chk("br_fire_valid", {31'h0, ifid_valid}, 32'h0);

        // flush overrides load; PC still advances
        if_flush = 1'b1;
        step();
        if_flush = 1'b0;
        chk("flush_instr", ifid_instr, 32'h0);
        chk("flush_valid", {31'h0, ifid_valid}, 32'h0);
        chk("flush_addr", bus.imem_addr, 32'h44);

        // misaligned target is aligned; top-of-memory fetch wraps to 0
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0;
        chk("align_addr", bus.imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        step();
        chk("wrap_addr", bus.imem_addr, 32'h0);
        push(32'h0);
        step();
        chk("post_wrap_addr", bus.imem_addr, 32'h4);

        // reset in the middle of DROP
        bus.imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
        step();
        branch_taken = 1'b0;
        chk("rdrop_addr", bus.imem_addr, 32'h4);
        rst_n = 1'b0;
        #1;
        chk("arst_addr", bus.imem_addr, 32'h0);
        chk("arst_req", {31'h0, bus.imem_req}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; bus.imem_ready = 1'b1;
        step();
        chk("arst_req_rise", {31'h0, bus.imem_req}, 32'h1);
        push(32'h0);
        step();
        chk("arst_fetch_addr", bus.imem_addr, 32'h4);

        // memory ready every third cycle, advance held
        exp_pc = 32'h4;
        for (int k = 0; k < 9; k++) begin
            rdy = ((k % 3) == 2);
            bus.imem_ready = rdy;
            #1;
            chk("pat_busy", {31'h0, fetch_busy}, {31'h0, ~rdy});
            if (rdy) push(exp_pc);
            step();
            chk("pat_valid", {31'h0, ifid_valid}, {31'h0, rdy});
            if (rdy) exp_pc = exp_pc + 32'd4;
        end
        chk("pat_addr", bus.imem_addr, exp_pc);

        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
